// File: rtl/cpu_pkg.sv
// Shared SimpleCPU datapath types and widths.
// Memory address and word widths are defined here so all stages agree.
package cpu_pkg;

   localparam int MEM_ADDR_W = 5;
   localparam int WORD_W     = 32;

   typedef logic [WORD_W-1:0]     word_t;
   typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

endpackage : cpu_pkg

// File: rtl/data_mem.sv
// Single-port word-addressed data memory for load/store instructions.
// Combinational read, synchronous write; reset clears every word in one edge.
module data_mem
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = MEM_ADDR_W,
   parameter int                DATA_W   = WORD_W,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] A,
   input  logic [DATA_W-1:0] WD,
   input  logic              WE,
   output logic [DATA_W-1:0] RD
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_reg [DEPTH];

   // Reset has priority over a write in the same cycle, so a store issued
   // alongside reset is dropped rather than landing in freshly cleared memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= INIT_VAL;
         end
      end else if (WE) begin
         mem_reg[A] <= WD;
      end
   end

   // Read is taken straight from the array, so a word written on an edge is
   // visible on RD immediately after that edge.
   assign RD = mem_reg[A];

endmodule : data_mem

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: stimulus pushes expected read data into a
// scoreboard queue, a monitor samples RD on request and compares.
module tb_data_mem;

   logic        clk;
   logic        rst;
   logic [4:0]  A;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] RD;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   sample_req = 1'b0;

   data_mem dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .WD  (WD),
      .WE  (WE),
      .RD  (RD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every sample request drains the queue against the current RD.
   initial begin
      exp_t e;
      forever begin
         @(sample_req);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (RD !== e.exp) begin
               bad++;
               $display("FAIL %s: RD=%h expected %h", e.name, RD, e.exp);
            end else begin
               $display("ok   %s: RD=%h", e.name, RD);
            end
         end
      end
   end

   // Set A, let the async read settle, then ask the monitor to compare.
   task automatic check(input logic [4:0] addr, input logic [31:0] exp, input string name);
      exp_t e;
      A = addr;
      #1;
      e.name = name;
      e.exp  = exp;
      exp_q.push_back(e);
      sample_req = ~sample_req;
      #1;
   endtask

   task automatic write_word(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      A  = addr;
      WD = data;
      WE = 1'b1;
      @(negedge clk);
      WE = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time=%0t required finish before 100000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] v;
      rst = 1'b1;
      WE  = 1'b1;
      A   = 5'd3;
      WD  = 32'hDEAD_BEEF;
      @(negedge clk);
      rst = 1'b0;
      WE  = 1'b0;
      WD  = '0;

      // Reset with a concurrent write: everything must read INIT_VAL
      for (int i = 0; i < 32; i++)
         check(5'(i), 32'h0, $sformatf("reset_sweep a=%0d", i));

      // Basic write / neighbours untouched
      write_word(5'd5, 32'h1234_5678);
      check(5'd5, 32'h1234_5678, "basic_rd a=5");
      check(5'd4, 32'h0, "basic_nbr a=4");
      check(5'd6, 32'h0, "basic_nbr a=6");

      // Async read: address changes within one half period, no edge
      @(negedge clk);
      check(5'd5, 32'h1234_5678, "async a=5");
      check(5'd0, 32'h0, "async a=0");
      check(5'd5, 32'h1234_5678, "async a=5 again");

      // Read during write to the same address
      write_word(5'd7, 32'hAAAA_AAAA);
      @(negedge clk);
      WD = 32'h5555_5555;
      WE = 1'b1;
      check(5'd7, 32'hAAAA_AAAA, "rdw before edge");
      @(posedge clk);
      #1;
      check(5'd7, 32'h5555_5555, "rdw after edge");
      WE = 1'b0;

      // Back-to-back fill of every word
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         A  = 5'(i);
         WD = i * 32'h0101_0101;
         WE = 1'b1;
      end
      @(negedge clk);
      WE = 1'b0;
      for (int i = 0; i < 32; i++) begin
         v = i * 32'h0101_0101;
         check(5'(i), v, $sformatf("fill a=%0d", i));
      end
      check(5'd31, 32'h1F1F_1F1F, "boundary a=31");

      // Reset mid-operation wipes the fill
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++)
         check(5'(i), 32'h0, $sformatf("mid_reset a=%0d", i));

      write_word(5'd31, 32'h0000_0001);
      check(5'd31, 32'h0000_0001, "post_reset_wr a=31");
      check(5'd30, 32'h0, "post_reset_nbr a=30");

      #5;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_data_mem

// File: doc/data_mem.md
Name: data_mem

Overview:
- Small single-port data memory for the SimpleCPU datapath: 32 words × 32 bits.
- Addressed by a 5-bit word address.
- Combinational (asynchronous) read, synchronous write on the rising clock edge.
- Sits beside the register file and serves load/store instructions from the execute/memory stage.

Parameters:
- ADDR_W, 5, word-address width; memory depth = 2**ADDR_W words.
- DATA_W, 32, data word width in bits.
- INIT_VAL, 0, value loaded into every word on reset (DATA_W bits).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- A  input  ADDR_W  word address, shared by read and write.
- WD  input  DATA_W  write data.
- WE  input  1  write enable, active-high.
- RD  output  DATA_W  read data.

Behaviour:
- Storage: array mem[0 .. 2**ADDR_W-1] of DATA_W-bit words. No byte enables. Word addressing only; A is not shifted internally.
- Read path:
  - RD = mem[A], purely combinational, zero latency.
  - RD follows A changes within the same cycle, with no clock edge needed.
- Write: on posedge clk with rst=0 and WE=1, mem[A] <= WD. With WE=0 the memory is unchanged.
- Reset:
  - On posedge clk with rst=1, every word is set to INIT_VAL in that single edge.
  - Reset overrides WE: any write in the same cycle is dropped.
  - Asserting reset mid-operation loses all previously stored data.
- Reset value of RD: INIT_VAL for any A once the reset edge has occurred.
- Power-up before the first reset: contents are undefined (X in simulation). Verification must apply reset first.
- Read-during-write, same address:
  - Before the edge, RD shows the old word.
  - Immediately after the edge, RD shows WD, because the read is async from the updated array.
- No out-of-range case: all 2**ADDR_W addresses are valid, and address 31 is a normal word. No wrap logic is needed.
- Back-to-back writes to different addresses on consecutive cycles are each committed independently.
- X on WE while rst=0 is a protocol violation; behaviour is not specified.

Decomposition:
- Shared package cpu_pkg holds:
  - constants MEM_ADDR_W = 5 and WORD_W = 32;
  - typedef word_t (logic [WORD_W-1:0]);
  - typedef mem_addr_t (logic [MEM_ADDR_W-1:0]).
- data_mem uses these package constants as its parameter defaults.
- No sub-module: a single always block for reset/write plus a continuous-assign read is sufficient.

Test Plan:
- Reset: assert rst for 1 cycle with WE=1, A=3, WD=32'hDEAD_BEEF; then sweep A=0..31 → RD=0 for every address, so the write was suppressed.
- Basic write/read:
  - Write A=5, WD=32'h1234_5678 for one cycle, then WE=0.
  - Read A=5 → RD=32'h1234_5678.
  - Read A=4 and A=6 → RD=0.
- Async read: with WE=0, change A between 5 and 0 mid-cycle → RD switches between 32'h1234_5678 and 0 in the same cycle, with no clock edge.
- Read-during-write:
  - Preload A=7 with 32'hAAAA_AAAA.
  - Set WE=1, WD=32'h5555_5555, A=7.
  - Before the edge, RD=32'hAAAA_AAAA; after the edge, RD=32'h5555_5555.
- Boundary and fill:
  - Write mem[i]=i*32'h0101_0101 for i=0..31 on back-to-back cycles, then read all → exact match.
  - Check A=31 specifically → 32'h1F1F_1F1F.
- Reset mid-operation: after the fill, pulse rst for 1 cycle → all 32 words read 0. A following write of A=31, WD=1 then reads back 1.
